icache_refill_controller: RTL and testbench

- Miss-refill sequencer for the two-port instruction cache.
- Takes miss requests from both fetch ports and grants one per refill with round-robin arbitration.
- Reads the missing line word-by-word from the memory port, then writes it into the cache data/tag array with a one-cycle fill strobe.
- Acknowledges every port whose miss the fill satisfies.

---
 rtl/icache_refill_controller_pkg.sv | 4 +
 rtl/icache_refill_controller_rr_arbiter_2.sv | 18 +
 rtl/icache_refill_controller.sv | 87 ++++++++
 tb/tb_icache_refill_controller.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/icache_refill_controller_pkg.sv
// icache_refill_controller_pkg: shared refill FSM state encoding
package icache_refill_controller_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, FILL} refill_state_e;
endpackage

// File: rtl/icache_refill_controller_rr_arbiter_2.sv
// rr_arbiter_2: two-requester round-robin grant with a one-bit priority register
//   request : per-port request
//   advance : grant is being taken this cycle, so rotate the priority
//   grant   : one-hot grant (zero when nothing requests)
module rr_arbiter_2 (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [1:0] request,
  input  logic       advance,
  output logic [1:0] grant
);
  logic prio;
  assign grant[0] = request[0] & (~request[1] | ~prio);
  assign grant[1] = request[1] & (~request[0] | prio);
  always_ff @(posedge i_clock)
    if (i_reset) prio <= 1'b0;
    else if (advance && |grant) prio <= grant[0];
endmodule

// File: rtl/icache_refill_controller.sv
// icache_refill_controller: two-port instruction cache miss refill sequencer
//   i_miss/i_miss_address : per-port miss level and byte address
//   o_miss_ack            : one-cycle pulse when a port's line is filled
//   o_mem_*/i_mem_*       : word-by-word memory read with ready handshake
//   o_fill_*              : one-cycle line write into the data/tag array
//   o_busy                : controller is not idle
module icache_refill_controller
  import icache_refill_controller_pkg::*;
#(
  parameter int SETS  = 8,
  parameter int WORDS = 4
) (
  input  logic                                        i_clock,
  input  logic                                        i_reset,
  input  logic [1:0]                                  i_miss,
  input  logic [1:0][31:0]                            i_miss_address,
  output logic [1:0]                                  o_miss_ack,
  output logic [31:0]                                 o_mem_address,
  output logic                                        o_mem_read,
  input  logic [31:0]                                 i_mem_data,
  input  logic                                        i_mem_ready,
  output logic                                        o_fill_write,
  output logic [$clog2(SETS)-1:0]                     o_fill_set,
  output logic [32-($clog2(SETS)+$clog2(WORDS)+2)-1:0] o_fill_tag,
  output logic [WORDS*32-1:0]                         o_fill_line,
  output logic                                        o_busy
);
  localparam int SetBits  = $clog2(SETS);
  localparam int WordBits = $clog2(WORDS);
  localparam int LineBits = 32 - WordBits - 2;
  refill_state_e state;
  logic [LineBits-1:0] line;
  logic [WordBits-1:0] count;
  logic [WORDS-1:0][31:0] buffer;
  logic granted;
  logic [1:0] grant;
  logic [1:0][LineBits-1:0] miss_line;
  logic fill;
  logic unused_offset;
  assign miss_line[0] = i_miss_address[0][31:WordBits+2];
  assign miss_line[1] = i_miss_address[1][31:WordBits+2];
  assign unused_offset = ^{i_miss_address[0][WordBits+1:0], i_miss_address[1][WordBits+1:0]};
  rr_arbiter_2 arbiter (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .request(i_miss),
    .advance(state == IDLE),
    .grant(grant)
  );
  always_ff @(posedge i_clock)
    if (i_reset) begin
      state   <= IDLE;
      line    <= '0;
      count   <= '0;
      buffer  <= '0;
      granted <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (|grant) begin
            line    <= grant[1] ? miss_line[1] : miss_line[0];
            granted <= grant[1];
            count   <= '0;
            state   <= FETCH;
          end
        FETCH:
          if (i_mem_ready) begin
            buffer[count] <= i_mem_data;
            // hold the counter on the last word; it only returns to 0 via IDLE
            count <= (count == WordBits'(WORDS - 1)) ? count : count + WordBits'(1);
            state <= (count == WordBits'(WORDS - 1)) ? FILL : FETCH;
          end
        default: state <= IDLE;
      endcase
    end
  assign fill          = (state == FILL);
  assign o_busy        = (state != IDLE);
  assign o_mem_read    = (state == FETCH);
  assign o_mem_address = o_mem_read ? {line, count, 2'b00} : 32'd0;
  assign o_fill_write  = fill;
  assign o_fill_set    = fill ? line[SetBits-1:0] : '0;
  assign o_fill_tag    = fill ? line[LineBits-1:SetBits] : '0;
  assign o_fill_line   = fill ? buffer : '0;
  // the non-granted port is acked too when it is waiting on the same line
  assign o_miss_ack[0] = fill & (~granted | (i_miss[0] & (miss_line[0] == line)));
  assign o_miss_ack[1] = fill & (granted | (i_miss[1] & (miss_line[1] == line)));
endmodule

// File: tb/tb_icache_refill_controller.sv
// tb_icache_refill_controller: directed self-checking bench for the refill controller
module tb_icache_refill_controller;
  logic i_clock = 0, i_reset = 1;
  logic [1:0] i_miss = '0;
  logic [1:0][31:0] i_miss_address = '0;
  logic [1:0] o_miss_ack;
  logic [31:0] o_mem_address, i_mem_data = '0;
  logic o_mem_read, i_mem_ready = 0, o_fill_write, o_busy;
  logic [2:0] o_fill_set;
  logic [24:0] o_fill_tag;
  logic [127:0] o_fill_line;
  int checks = 0, failures = 0;

  icache_refill_controller dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_miss(i_miss), .i_miss_address(i_miss_address),
    .o_miss_ack(o_miss_ack), .o_mem_address(o_mem_address), .o_mem_read(o_mem_read),
    .i_mem_data(i_mem_data), .i_mem_ready(i_mem_ready), .o_fill_write(o_fill_write),
    .o_fill_set(o_fill_set), .o_fill_tag(o_fill_tag), .o_fill_line(o_fill_line), .o_busy(o_busy)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic idle_check(input string tag);
    check(tag, {o_busy, o_mem_read, o_fill_write, o_miss_ack}, 5'b0);
  endtask

  // drives the memory for one whole line starting in the first FETCH cycle;
  // ends in the cycle where the fill is expected
  task automatic run_fetch(input string tag, input logic [31:0] base, input logic [31:0] d0,
                           input int stall_word, input int stalls, input int drop_word);
    for (int w = 0; w < 4; w++) begin
      if (w == drop_word) i_miss[0] = 1'b0;
      if (w == stall_word)
        for (int s = 0; s < stalls; s++) begin
          i_mem_ready = 0;
          #1 check({tag, "_stall"}, {o_mem_read, o_fill_write, o_miss_ack, o_mem_address},
                   {1'b1, 1'b0, 2'b00, base + 32'(4 * w)});
          tick();
        end
      i_mem_ready = 1;
      i_mem_data = d0 + 32'(w);
      #1 check({tag, "_fetch"}, {o_mem_read, o_fill_write, o_miss_ack, o_mem_address},
               {1'b1, 1'b0, 2'b00, base + 32'(4 * w)});
      tick();
    end
    i_mem_ready = 0;
  endtask

  task automatic check_fill(input string tag, input logic [2:0] set, input logic [24:0] tg,
                            input logic [31:0] d0, input logic [1:0] ack);
    check({tag, "_fill"}, {o_fill_write, o_mem_read, o_busy, o_fill_set, o_fill_tag, o_miss_ack},
          {1'b1, 1'b0, 1'b1, set, tg, ack});
    check({tag, "_line"}, o_fill_line, {d0 + 32'd3, d0 + 32'd2, d0 + 32'd1, d0});
  endtask

  initial begin
    tick();
    tick();
    idle_check("reset_ctl");
    check("reset_addr", o_mem_address, 0);
    i_reset = 0;
    // simultaneous misses on different lines: port 0 first
    i_miss = 2'b11;
    i_miss_address[0] = 32'h2000;
    i_miss_address[1] = 32'h3010;
    #1 idle_check("pair1_idle");
    tick();
    run_fetch("pair1a", 32'h2000, 32'hB0, -1, 0, -1);
    check_fill("pair1a", 3'd0, 25'h40, 32'hB0, 2'b01);
    i_miss[0] = 0;
    tick();
    idle_check("pair1_gap");
    tick();
    run_fetch("pair1b", 32'h3010, 32'hC0, -1, 0, -1);
    check_fill("pair1b", 3'd1, 25'h60, 32'hC0, 2'b10);
    i_miss[1] = 0;
    tick();
    idle_check("pair1_done");
    // single miss, unstalled: fill lands at cycle 1+WORDS
    i_miss = 2'b01;
    i_miss_address[0] = 32'h1234;
    tick();
    run_fetch("single", 32'h1230, 32'hA0, -1, 0, -1);
    check_fill("single", 3'd3, 25'h24, 32'hA0, 2'b01);
    check("single_line", o_fill_line, 128'h000000A3_000000A2_000000A1_000000A0);
    i_miss = 0;
    tick();
    idle_check("single_idle");
    tick();
    idle_check("single_nodup");
    // last grant was port 0, so the next simultaneous pair starts with port 1
    i_miss = 2'b11;
    i_miss_address[0] = 32'h8000;
    i_miss_address[1] = 32'h9020;
    tick();
    run_fetch("pair2a", 32'h9020, 32'hD0, -1, 0, -1);
    check_fill("pair2a", 3'd2, 25'h120, 32'hD0, 2'b10);
    i_miss[1] = 0;
    tick();
    idle_check("pair2_gap");
    tick();
    run_fetch("pair2b", 32'h8000, 32'h11, -1, 0, -1);
    check_fill("pair2b", 3'd0, 25'h100, 32'h11, 2'b01);
    i_miss[0] = 0;
    tick();
    // same line from both ports: one fetch, both acked together
    i_miss = 2'b11;
    i_miss_address[0] = 32'h400;
    i_miss_address[1] = 32'h408;
    tick();
    run_fetch("same", 32'h400, 32'h40, -1, 0, -1);
    check_fill("same", 3'd0, 25'h8, 32'h40, 2'b11);
    i_miss = 0;
    tick();
    idle_check("same_idle");
    tick();
    idle_check("same_nodup");
    // three stall cycles on word 2
    i_miss = 2'b01;
    i_miss_address[0] = 32'h5008;
    tick();
    run_fetch("stall", 32'h5000, 32'h50, 2, 3, -1);
    check_fill("stall", 3'd0, 25'hA0, 32'h50, 2'b01);
    i_miss = 0;
    tick();
    // reset mid-FETCH after word 1, then a clean refetch from word 0
    i_miss = 2'b01;
    i_miss_address[0] = 32'h6000;
    tick();
    i_mem_ready = 1;
    i_mem_data = 32'hE0;
    tick();
    i_mem_data = 32'hE1;
    tick();
    i_reset = 1;
    i_mem_ready = 0;
    tick();
    check("rst_mid", {o_mem_read, o_busy, o_fill_write, o_miss_ack, o_mem_address}, 0);
    i_reset = 0;
    tick();
    run_fetch("refetch", 32'h6000, 32'hF0, -1, 0, -1);
    check_fill("refetch", 3'd0, 25'hC0, 32'hF0, 2'b01);
    i_miss = 0;
    tick();
    // miss dropped mid-FETCH still completes and acks
    i_miss = 2'b01;
    i_miss_address[0] = 32'h7000;
    tick();
    run_fetch("drop", 32'h7000, 32'h70, -1, 0, 2);
    check_fill("drop", 3'd0, 25'hE0, 32'h70, 2'b01);
    tick();
    idle_check("drop_idle");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
